// File: rtl/mac_array.sv
// mac_array: LANES-wide multiply-accumulate engine with run sequencer and valid/ready handshakes
// Ports: clk, rst_mem (sync active-high), cfg_signed/cfg_len/start (run setup, sampled on accepted start),
//   busy, in_valid/in_ready/img_in/weight_in (operand beats), out_valid/out_ready/mac_out/sat_flag (result).
// Optional MAC_SAT_EN: saturating per-lane accumulate with sticky sat_flag; otherwise modulo wrap.
module mac_array #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 22,
  parameter int LANES     = 4,
  parameter int MAX_LEN   = 256,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                           clk,
  input  logic                           rst_mem,
  input  logic                           cfg_signed,
  input  logic [LEN_W-1:0]               cfg_len,
  input  logic                           start,
  output logic                           busy,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*IN_WIDTH-1:0]      img_in,
  input  logic [LANES*IN_WIDTH-1:0]      weight_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*OUT_WIDTH-1:0]     mac_out,
  output logic [LANES-1:0]               sat_flag
);
  localparam int PW = 2 * IN_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic sgn_q, mv_q, go, beat, last;
  assign go        = (state_q == IDLE) && start;
  assign in_ready  = state_q == RUN;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign beat      = in_valid && in_ready;
  assign last      = cnt_q == len_q - LEN_W'(1);
  always_comb begin
    state_d = state_q == IDLE  ? (start ? (cfg_len == '0 ? DONE : RUN) : IDLE) :
              state_q == RUN   ? (beat && last ? DRAIN : RUN) :
              state_q == DRAIN ? DONE :
                                 (out_ready ? IDLE : DONE);
  end
  // mv_q marks that mul regs were loaded last edge, so acc only adds real beats
  always_ff @(posedge clk) begin
    if (rst_mem) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mv_q    <= beat;
      if (go) begin
        len_q <= cfg_len;
        sgn_q <= cfg_signed;
        cnt_q <= '0;
      end else if (beat) cnt_q <= cnt_q + LEN_W'(1);
    end
  end
`ifdef MAC_SAT_EN
  logic [LANES-1:0] sat_q, sat_set;
  always_ff @(posedge clk) begin
    if (rst_mem || go) sat_q <= '0;
    else sat_q <= sat_q | sat_set;
  end
  assign sat_flag = sat_q;
`else
  assign sat_flag = '0;
`endif
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IN_WIDTH-1:0]  a, b;
    logic [PW-1:0]        mul_q, mul_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d, addend;
    assign a = img_in[k*IN_WIDTH +: IN_WIDTH];
    assign b = weight_in[k*IN_WIDTH +: IN_WIDTH];
    // low PW bits of the product are the same for signed and unsigned once operands are extended
    assign mul_d  = {{IN_WIDTH{sgn_q & a[IN_WIDTH-1]}}, a} * {{IN_WIDTH{sgn_q & b[IN_WIDTH-1]}}, b};
    assign addend = {{(OUT_WIDTH-PW){sgn_q & mul_q[PW-1]}}, mul_q};
`ifdef MAC_SAT_EN
    logic [OUT_WIDTH:0] sum;
    logic ovf;
    assign sum = {sgn_q & acc_q[OUT_WIDTH-1], acc_q} + {sgn_q & addend[OUT_WIDTH-1], addend};
    assign ovf = sgn_q ? sum[OUT_WIDTH] ^ sum[OUT_WIDTH-1] : sum[OUT_WIDTH];
    assign acc_d = !ovf ? sum[OUT_WIDTH-1:0] :
                   !sgn_q ? '1 :
                   sum[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    assign sat_set[k] = mv_q && ovf;
`else
    assign acc_d = acc_q + addend;
`endif
    always_ff @(posedge clk) begin
      if (rst_mem || go) begin
        mul_q <= '0;
        acc_q <= '0;
      end else begin
        if (beat) mul_q <= mul_d;
        if (mv_q) acc_q <= acc_d;
      end
    end
    assign mac_out[k*OUT_WIDTH +: OUT_WIDTH] = acc_q;
  end
endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: directed self-checking bench for mac_array
module tb_mac_array;
  localparam int LEN_W = 9;
  logic clk = 1'b0;
  logic rst_mem, cfg_signed, start, busy, in_valid, in_ready, out_valid, out_ready;
  logic [LEN_W-1:0] cfg_len;
  logic [31:0] img_in, weight_in;
  logic [87:0] mac_out;
  logic [3:0] sat_flag;
  int checks = 0;
  int errors = 0;

  mac_array dut (
    .clk(clk), .rst_mem(rst_mem), .cfg_signed(cfg_signed), .cfg_len(cfg_len), .start(start),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .img_in(img_in), .weight_in(weight_in),
    .out_valid(out_valid), .out_ready(out_ready), .mac_out(mac_out), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lanes(input logic [7:0] a, input logic [7:0] b);
    img_in = {4{a}};
    weight_in = {4{b}};
  endtask

  task automatic begin_run(input logic sgn, input int len);
    cfg_signed = sgn;
    cfg_len = LEN_W'(len);
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // start, stream len steady beats, leave the DUT in DRAIN
  task automatic run(input logic sgn, input int len, input logic [7:0] a, input logic [7:0] b);
    begin_run(sgn, len);
    lanes(a, b);
    in_valid = 1'b1;
    repeat (len) tick;
    in_valid = 1'b0;
  endtask

  task automatic ack;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [87:0] held;
    rst_mem = 1'b1; cfg_signed = 1'b0; cfg_len = '0; start = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; img_in = '0; weight_in = '0;
    tick; tick;
    rst_mem = 1'b0;
    chk("reset busy", busy, 1'b0);
    chk("reset in_ready", in_ready, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset mac_out", mac_out, 88'd0);
    chk("reset sat_flag", sat_flag, 4'h0);

    // T1
    begin_run(1'b0, 3);
    chk("t1 busy", busy, 1'b1);
    chk("t1 in_ready", in_ready, 1'b1);
    lanes(8'd255, 8'd255);
    in_valid = 1'b1;
    repeat (3) tick;
    in_valid = 1'b0;
    chk("t1 drain in_ready", in_ready, 1'b0);
    chk("t1 drain out_valid", out_valid, 1'b0);
    tick;
    chk("t1 out_valid", out_valid, 1'b1);
    chk("t1 mac_out", mac_out, {4{22'd195075}});
    chk("t1 sat_flag", sat_flag, 4'h0);
    ack;
    chk("t1 idle busy", busy, 1'b0);
    chk("t1 idle out_valid", out_valid, 1'b0);

    // T2
    run(1'b1, 4, 8'h80, 8'h7F);
    tick;
    chk("t2 signed", mac_out, {4{22'h3F0200}});
    ack;
    run(1'b0, 4, 8'h80, 8'h7F);
    tick;
    chk("t2 unsigned", mac_out, {4{22'd65024}});
    ack;

    // T3: gapped beats, stalled consumer, start ignored
    begin_run(1'b0, 3);
    lanes(8'd2, 8'd3);
    in_valid = 1'b1; tick;
    in_valid = 1'b0; tick;
    in_valid = 1'b1; tick;
    in_valid = 1'b0; tick;
    chk("t3 mid out_valid", out_valid, 1'b0);
    in_valid = 1'b1; tick;
    in_valid = 1'b0; tick;
    chk("t3 out_valid", out_valid, 1'b1);
    chk("t3 mac_out", mac_out, {4{22'd18}});
    held = mac_out;
    start = 1'b1; cfg_len = 9'd5; cfg_signed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t3 stall out_valid", out_valid, 1'b1);
      chk("t3 stall mac_out", mac_out, {4{22'd18}});
    end
    out_ready = 1'b1;
    tick;
    start = 1'b0; out_ready = 1'b0;
    chk("t3 start+ready busy", busy, 1'b0);
    chk("t3 held value", held, {4{22'd18}});

    // T4: overflow in both modes
    run(1'b0, 65, 8'd255, 8'd255);
    tick;
`ifdef MAC_SAT_EN
    chk("t4 unsigned mac_out", mac_out, {4{22'h3FFFFF}});
    chk("t4 unsigned sat_flag", sat_flag, 4'hF);
`else
    chk("t4 unsigned mac_out", mac_out, {4{22'd32321}});
    chk("t4 unsigned sat_flag", sat_flag, 4'h0);
`endif
    ack;
    run(1'b1, 200, 8'h80, 8'h7F);
    tick;
`ifdef MAC_SAT_EN
    chk("t4 signed mac_out", mac_out, {4{22'h200000}});
    chk("t4 signed sat_flag", sat_flag, 4'hF);
`else
    chk("t4 signed mac_out", mac_out, {4{22'h0E6400}});
    chk("t4 signed sat_flag", sat_flag, 4'h0);
`endif
    ack;

    // T5: reset mid-run
    begin_run(1'b0, 3);
    chk("t5 sat cleared on start", sat_flag, 4'h0);
    lanes(8'd5, 8'd7);
    in_valid = 1'b1;
    tick;
    rst_mem = 1'b1;
    tick;
    rst_mem = 1'b0; in_valid = 1'b0;
    chk("t5 rst busy", busy, 1'b0);
    chk("t5 rst mac_out", mac_out, 88'd0);
    chk("t5 rst in_ready", in_ready, 1'b0);
    chk("t5 rst out_valid", out_valid, 1'b0);
    run(1'b0, 1, 8'd5, 8'd7);
    tick;
    chk("t5 out_valid", out_valid, 1'b1);
    chk("t5 mac_out", mac_out, {4{22'd35}});
    ack;

    // T6: zero-length run
    lanes(8'd9, 8'd9);
    in_valid = 1'b1;
    begin_run(1'b0, 0);
    chk("t6 out_valid", out_valid, 1'b1);
    chk("t6 mac_out", mac_out, 88'd0);
    chk("t6 in_ready", in_ready, 1'b0);
    tick;
    chk("t6 held mac_out", mac_out, 88'd0);
    in_valid = 1'b0;
    ack;
    chk("t6 idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
